pipe_reg: RTL and testbench

- Parametrised elastic pipeline register: a chain of DEPTH D-type stages, each DATA_WIDTH wide, with a valid bit per stage and a valid/ready handshake on both ends.
- Generalises the single-bit clocked D register into a multi-stage, back-pressure-aware delay line.
- Used between datapath units (fetch/decode/execute boundaries) where a stage must stall or be flushed without losing or duplicating data.

---
 rtl/pipe_reg.sv | 126 ++++++++++++
 tb/tb_pipe_reg.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg.sv
// Elastic pipeline register: DEPTH valid/data stages with valid/ready on both ends.
// Optional occupancy output `count` is built when PIPE_REG_COUNT_EN is defined.
module pipe_reg #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    DEPTH       = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          clear_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
`ifdef PIPE_REG_COUNT_EN
    output logic [$clog2(DEPTH+1)-1:0]    count,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; valid never waits on ready, and ready never depends on in_valid.

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [DEPTH-1:0]      rdy;
    logic [DEPTH-1:0]      adv;
    logic                  in_ready_c;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];

    // Walk from the output back: a stage may move if everything downstream of it
    // either drains or contains a bubble, so a single accumulator is enough.
    always_comb begin : ready_chain
        logic acc;
        rdy = '0;
        adv = '0;
        acc = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = acc;
            adv[i] = valid_q[i] & acc;
            acc    = acc | ~valid_q[i];
        end
        in_ready_c = acc;
    end

    always_comb begin : next_state
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_c) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = in_data;
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i-1]) begin
                valid_d[i] = valid_q[i-1];
                if (adv[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
        // Flush empties the pipe but leaves the payload registers untouched.
        if (flush) begin
            valid_d = '0;
            data_d  = data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VALUE;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

`ifdef PIPE_REG_COUNT_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = CW'($countones(valid_d));
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
`endif

    assign in_ready  = in_ready_c;
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

`ifdef FORMAL
    logic f_past_q;

    always_ff @(posedge clk) begin
        f_past_q <= 1'b1;
        if (f_past_q && $past(clear_n) && $past(out_valid & ~out_ready)) begin
            assert (out_data == $past(out_data));
        end
        if (f_past_q && !$past(clear_n)) begin
            assert (!out_valid);
        end
        assert ($countones(valid_q) <= DEPTH);
    end
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: directed scenarios plus random traffic, checked by a
// queue-based reference of the items the pipe currently holds.
module tb_pipe_reg;

    localparam int             DW    = 8;
    localparam int             DEPTH = 3;
    localparam logic [DW-1:0]  RV    = 8'hFF;

    logic          clk = 1'b0;
    logic          clear_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef PIPE_REG_COUNT_EN
    logic [$clog2(DEPTH+1)-1:0] count;
`endif

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic          mon_en = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    pipe_reg #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RESET_VALUE(RV)
    ) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
`ifdef PIPE_REG_COUNT_EN
        .count    (count),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("send_accept", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 40 && (out_valid || exp_q.size() != 0); t++) tick();
        chk("drain_empty", out_valid, 0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    // The pipe is modelled as a plain FIFO of accepted items: acceptance pushes,
    // emission pops, flush/reset discard everything not emitted that cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready_rule", in_ready, out_ready | (exp_q.size() < DEPTH));
`ifdef PIPE_REG_COUNT_EN
            chk("count", count, exp_q.size());
`endif
            if (exp_q.size() == 0) chk("out_valid_when_empty", out_valid, 0);
            if (prev_stall) chk("stall_stable", out_data, prev_data);
            if (out_valid && out_ready && clear_n && exp_q.size() != 0)
                chk("out_data", out_data, exp_q.pop_front());
            if (!clear_n || flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(in_data);
            prev_stall = out_valid & ~out_ready & clear_n;
            prev_data  = out_data;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        clear_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        clear_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, RV);
        chk("rst_in_ready", in_ready, 1);
        mon_en = 1'b1;

        // back-to-back stream with latency check
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        chk("t1_lat_pre", out_valid, 0);
        in_data = 8'h33;
        tick();
        in_valid = 1'b0;
        chk("t1_lat_first", out_valid, 1);
        chk("t1_first_data", out_data, 8'h11);
        drain();

        // back-pressure: fill, hold one more at the input, then release
        out_ready = 1'b0;
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        in_valid = 1'b1;
        in_data  = 8'hA4;
        repeat (3) begin
            @(negedge clk);
            chk("t2_in_ready_full", in_ready, 0);
            chk("t2_out_valid", out_valid, 1);
            chk("t2_head", out_data, 8'hA1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_accept_on_release", in_ready, 1);
        tick();
        in_valid = 1'b0;
        drain();

        // full pipe, simultaneous accept and emit
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) send(DW'($urandom));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h5C;
        repeat (8) begin
            @(negedge clk);
            chk("t3_in_ready", in_ready, 1);
            chk("t3_full", out_valid, 1);
            tick();
        end
        in_valid = 1'b0;
        drain();

        // flush with concurrent input (dropped) and output (completed)
        out_ready = 1'b0;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4_out_valid", out_valid, 0);
        chk("t4_in_ready", in_ready, 1);
        repeat (6) tick();

        // mid-stream reset overrides flush and input
        in_valid = 1'b1;
        repeat (2) begin
            in_data = DW'($urandom);
            tick();
        end
        clear_n   = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b0;
        in_data   = 8'h99;
        tick();
        clear_n  = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_out_data", out_data, RV);
        chk("t5_in_ready", in_ready, 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h42;
        tick();
        in_valid = 1'b0;
        repeat (DEPTH - 1) begin
            chk("t5_lat_pre", out_valid, 0);
            tick();
        end
        chk("t5_lat_out", out_valid, 1);
        chk("t5_lat_data", out_data, 8'h42);
        drain();

        // bubble collapse under a stalled output
        out_ready = 1'b0;
        send(8'h10);
        repeat (2) tick();
        send(8'h20);
        tick();
        chk("t6_in_ready", in_ready, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_first_valid", out_valid, 1);
        chk("t6_first_data", out_data, 8'h10);
        tick();
        chk("t6_second_valid", out_valid, 1);
        chk("t6_second_data", out_data, 8'h20);
        drain();

        // random traffic with occasional flush and reset
        repeat (400) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) begin
                clear_n   = 1'b0;
                out_ready = 1'b0;
            end else begin
                clear_n = 1'b1;
            end
            tick();
        end
        clear_n = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
